// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage:
// control-word layout, decode bit positions and FSM state encoding.
package mem_access_stage_pkg;

  localparam int CTRL_W     = 22;
  localparam int IDX_LD_C   = 0;
  localparam int IDX_ST_C   = 1;
  localparam int IDX_CALL_C = 4;

  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef enum logic {
    IDLE_ST = 1'b0,
    WAIT_ST = 1'b1
  } state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and the memory (slave).
interface mem_access_stage_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/ma_timeout_ctr.sv
// 8-bit wait-cycle counter; expired flags the last cycle allowed before a
// memory access is forced to complete.
module ma_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count_r;

  // Count wait cycles; clear takes priority over enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= 8'd0;
    end else if (clr) begin
      count_r <= 8'd0;
    end else if (en) begin
      count_r <= count_r + 8'd1;
    end
  end

  assign expired = (count_r == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: ALU ops pass through in one cycle, aligned
// loads/stores stall upstream until mem_ack or timeout.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int IDX_LD  = IDX_LD_C,
  parameter int IDX_ST  = IDX_ST_C
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [31:0]             pc_in,
  input  logic [31:0]             aluResult_in,
  input  logic [31:0]             op2_in,
  input  logic [31:0]             inst_in,
  input  ctrl_t                   control_in,
  output logic                    stall_out,
  mem_access_stage_if.master      mem,
  output logic                    valid_out,
  output logic [31:0]             pc_out,
  output logic [31:0]             ldResult,
  output logic [31:0]             aluResult_out,
  output logic [31:0]             inst_out,
  output ctrl_t                   control_out,
  output logic                    mem_err
);

  state_t      state_r, next_state_s;
  logic [31:0] hold_pc_r, hold_alu_r, hold_op2_r, hold_inst_r;
  ctrl_t       hold_ctrl_r;

  logic mem_op_s, aligned_s, in_wait_s, expired_s;
  logic accept_s, done_direct_s, done_mem_s, timeout_s, misaligned_s;
  logic ctr_clr_s, ctr_en_s;

  assign mem_op_s  = control_in[IDX_LD] | control_in[IDX_ST];
  assign aligned_s = (aluResult_in[1:0] == 2'b00);
  assign in_wait_s = (state_r == WAIT_ST);

  ma_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (ctr_clr_s),
    .en      (ctr_en_s),
    .expired (expired_s)
  );

  // Next-state and completion decode; an ack beats a simultaneous timeout.
  always_comb begin
    next_state_s  = state_r;
    accept_s      = 1'b0;
    done_direct_s = 1'b0;
    done_mem_s    = 1'b0;
    timeout_s     = 1'b0;
    misaligned_s  = 1'b0;
    ctr_clr_s     = 1'b0;
    ctr_en_s      = 1'b0;
    case (state_r)
      IDLE_ST: begin
        if (valid_in) begin
          if (mem_op_s && aligned_s) begin
            next_state_s = WAIT_ST;
            accept_s     = 1'b1;
            ctr_clr_s    = 1'b1;
          end else begin
            next_state_s  = IDLE_ST;
            done_direct_s = 1'b1;
            misaligned_s  = mem_op_s;
          end
        end else begin
          next_state_s = IDLE_ST;
        end
      end
      WAIT_ST: begin
        ctr_en_s = 1'b1;
        if (mem.mem_ack) begin
          next_state_s = IDLE_ST;
          done_mem_s   = 1'b1;
        end else if (expired_s) begin
          next_state_s = IDLE_ST;
          done_mem_s   = 1'b1;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = WAIT_ST;
        end
      end
      default: begin
        next_state_s = IDLE_ST;
      end
    endcase
  end

  // State, hold registers, writeback outputs and the sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= IDLE_ST;
      hold_pc_r     <= 32'd0;
      hold_alu_r    <= 32'd0;
      hold_op2_r    <= 32'd0;
      hold_inst_r   <= 32'd0;
      hold_ctrl_r   <= '0;
      valid_out     <= 1'b0;
      pc_out        <= 32'd0;
      ldResult      <= 32'd0;
      aluResult_out <= 32'd0;
      inst_out      <= 32'd0;
      control_out   <= '0;
      mem_err       <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      valid_out <= done_direct_s | done_mem_s;
      if (accept_s) begin
        hold_pc_r   <= pc_in;
        hold_alu_r  <= aluResult_in;
        hold_op2_r  <= op2_in;
        hold_inst_r <= inst_in;
        hold_ctrl_r <= control_in;
      end
      if (done_direct_s) begin
        pc_out        <= pc_in;
        ldResult      <= 32'd0;
        aluResult_out <= aluResult_in;
        inst_out      <= inst_in;
        control_out   <= control_in;
      end else if (done_mem_s) begin
        pc_out        <= hold_pc_r;
        ldResult      <= (mem.mem_ack && hold_ctrl_r[IDX_LD]) ? mem.mem_rdata : 32'd0;
        aluResult_out <= hold_alu_r;
        inst_out      <= hold_inst_r;
        control_out   <= hold_ctrl_r;
      end
      if (misaligned_s || timeout_s) begin
        mem_err <= 1'b1;
      end
    end
  end

  // A set isLd overrides isSt, so a both-bits word never writes.
  assign stall_out     = in_wait_s;
  assign mem.mem_req   = in_wait_s;
  assign mem.mem_we    = in_wait_s & hold_ctrl_r[IDX_ST] & ~hold_ctrl_r[IDX_LD];
  assign mem.mem_addr  = in_wait_s ? hold_alu_r : 32'd0;
  assign mem.mem_wdata = in_wait_s ? hold_op2_r : 32'd0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, reset
// sequences and randomized instructions against a transaction-level model.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst, valid_in;
  logic [31:0] pc_in, aluResult_in, op2_in, inst_in;
  ctrl_t       control_in;
  logic        stall_out, valid_out, mem_err;
  logic [31:0] pc_out, ldResult, aluResult_out, inst_out;
  ctrl_t       control_out;

  mem_access_stage_if mif();

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .pc_in         (pc_in),
    .aluResult_in  (aluResult_in),
    .op2_in        (op2_in),
    .inst_in       (inst_in),
    .control_in    (control_in),
    .stall_out     (stall_out),
    .mem           (mif),
    .valid_out     (valid_out),
    .pc_out        (pc_out),
    .ldResult      (ldResult),
    .aluResult_out (aluResult_out),
    .inst_out      (inst_out),
    .control_out   (control_out),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_before;
    logic [31:0] pc, alu, op2, inst;
    logic [21:0] ctrl;
    int          ack_at;    // WAIT cycle (1-based) in which mem_ack is pulsed; 0 = never
    logic [31:0] rdata;
    int          exp_wait;  // expected number of WAIT cycles
    logic [31:0] exp_ld;
    logic        exp_err;   // expected mem_err after completion
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  logic  err_model = 1'b0;
  string cur_tag = "";
  vec_t  tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h at %0t", cur_tag, name, act, exp, $time);
    end
  endtask

  // Expected behaviour of one instruction, worked out from the stage's rules.
  function automatic vec_t model(input vec_t v, input logic err_prev);
    vec_t r;
    logic is_mem, mis;
    r       = v;
    is_mem  = v.ctrl[0] | v.ctrl[1];
    mis     = is_mem && (v.alu[1:0] != 2'b00);
    r.exp_err = err_prev;
    if (!is_mem || mis) begin
      r.exp_wait = 0;
      r.exp_ld   = 32'h0;
      if (mis) r.exp_err = 1'b1;
    end else if (v.ack_at >= 1 && v.ack_at <= TO) begin
      r.exp_wait = v.ack_at;
      r.exp_ld   = v.ctrl[0] ? v.rdata : 32'h0;
    end else begin
      r.exp_wait = TO;
      r.exp_ld   = 32'h0;
      r.exp_err  = 1'b1;
    end
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b0; valid_in = 1'b0; mif.mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    err_model = 1'b0;
  endtask

  // Issue one instruction at a negedge and follow it to completion plus one idle cycle.
  task automatic run_instr(input vec_t v);
    logic is_st;
    is_st = v.ctrl[1] & ~v.ctrl[0];
    valid_in = 1'b1; pc_in = v.pc; aluResult_in = v.alu; op2_in = v.op2;
    inst_in = v.inst; control_in = v.ctrl; mif.mem_ack = 1'b0;
    for (int c = 1; c <= v.exp_wait; c++) begin
      @(negedge clk);
      chk("stall", {31'd0, stall_out}, 32'd1);
      chk("mem_req", {31'd0, mif.mem_req}, 32'd1);
      chk("mem_we", {31'd0, mif.mem_we}, {31'd0, is_st});
      chk("mem_addr", mif.mem_addr, v.alu);
      chk("mem_wdata", mif.mem_wdata, v.op2);
      chk("valid_wait", {31'd0, valid_out}, 32'd0);
      mif.mem_ack   = (c == v.ack_at);
      mif.mem_rdata = (c == v.ack_at) ? v.rdata : $urandom();
    end
    @(negedge clk);
    chk("valid_out", {31'd0, valid_out}, 32'd1);
    chk("stall_done", {31'd0, stall_out}, 32'd0);
    chk("mem_req_done", {31'd0, mif.mem_req}, 32'd0);
    chk("pc_out", pc_out, v.pc);
    chk("aluResult_out", aluResult_out, v.alu);
    chk("inst_out", inst_out, v.inst);
    chk("control_out", {10'd0, control_out}, {10'd0, v.ctrl});
    chk("ldResult", ldResult, v.exp_ld);
    chk("mem_err", {31'd0, mem_err}, {31'd0, v.exp_err});
    valid_in = 1'b0; pc_in = $urandom();
    mif.mem_ack = 1'($urandom_range(0, 1)); mif.mem_rdata = $urandom();
    @(negedge clk);
    chk("valid_pulse", {31'd0, valid_out}, 32'd0);
    chk("stall_idle", {31'd0, stall_out}, 32'd0);
    chk("mem_req_idle", {31'd0, mif.mem_req}, 32'd0);
    chk("mem_we_idle", {31'd0, mif.mem_we}, 32'd0);
    chk("mem_addr_idle", mif.mem_addr, 32'd0);
    chk("mem_wdata_idle", mif.mem_wdata, 32'd0);
    chk("mem_err_idle", {31'd0, mem_err}, {31'd0, v.exp_err});
    mif.mem_ack = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [31:0] tmp;
    int kind, r;

    // rst_before, pc, alu, op2, inst, ctrl, ack_at, rdata, exp_wait, exp_ld, exp_err
    tbl[0] = '{1'b0, 32'h10, 32'h5, 32'h0, 32'h13, 22'h0, 0, 32'h0, 0, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 32'h1234, 32'hFFFF_FFFF, 32'h77, 32'hABCD, 22'h3FFFFC, 0, 32'h0, 0, 32'h0, 1'b0};
    tbl[2] = '{1'b0, 32'h20, 32'h100, 32'h0, 32'h03, 22'h1, 3, 32'hA, 3, 32'hA, 1'b0};
    tbl[3] = '{1'b0, 32'h24, 32'h200, 32'hDEAD_BEEF, 32'h23, 22'h2, 2, 32'h5555_5555, 2, 32'h0, 1'b0};
    tbl[4] = '{1'b0, 32'h28, 32'h300, 32'h11, 32'h07, 22'h13, 1, 32'h1234_5678, 1, 32'h1234_5678, 1'b0};
    tbl[5] = '{1'b0, 32'h2C, 32'h40, 32'h0, 32'h03, 22'h1, 15, 32'hCAFE_F00D, 15, 32'hCAFE_F00D, 1'b0};
    tbl[6] = '{1'b0, 32'h30, 32'h102, 32'h0, 32'h03, 22'h1, 0, 32'h0, 0, 32'h0, 1'b1};
    tbl[7] = '{1'b1, 32'h34, 32'h104, 32'h0, 32'h03, 22'h1, 0, 32'h0, 15, 32'h0, 1'b1};
    tbl[8] = '{1'b0, 32'h38, 32'h9, 32'h0, 32'h33, 22'h0, 0, 32'h0, 0, 32'h0, 1'b1};
    tbl[9] = '{1'b1, 32'h3C, 32'h201, 32'h99, 32'h23, 22'h2, 0, 32'h0, 0, 32'h0, 1'b1};

    rst = 1'b0; valid_in = 1'b0; pc_in = 32'd0; aluResult_in = 32'd0; op2_in = 32'd0;
    inst_in = 32'd0; control_in = '0; mif.mem_ack = 1'b0; mif.mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    cur_tag = "reset";
    chk("valid_out", {31'd0, valid_out}, 32'd0);
    chk("stall", {31'd0, stall_out}, 32'd0);
    chk("mem_req", {31'd0, mif.mem_req}, 32'd0);
    chk("mem_addr", mif.mem_addr, 32'd0);
    chk("pc_out", pc_out, 32'd0);
    chk("ldResult", ldResult, 32'd0);
    chk("control_out", {10'd0, control_out}, 32'd0);
    chk("mem_err", {31'd0, mem_err}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      $sformat(cur_tag, "vec%0d", i);
      if (tbl[i].rst_before) do_reset();
      run_instr(tbl[i]);
      err_model = tbl[i].exp_err;
    end

    // Reset on the second WAIT cycle abandons the load; a late ack is ignored.
    do_reset();
    cur_tag = "rst_mid_wait";
    valid_in = 1'b1; pc_in = 32'h44; aluResult_in = 32'h180; op2_in = 32'h0;
    inst_in = 32'h03; control_in = 22'h1;
    @(negedge clk);
    chk("stall_w1", {31'd0, stall_out}, 32'd1);
    @(negedge clk);
    chk("mem_req_w2", {31'd0, mif.mem_req}, 32'd1);
    rst = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    chk("stall", {31'd0, stall_out}, 32'd0);
    chk("mem_req", {31'd0, mif.mem_req}, 32'd0);
    chk("valid_out", {31'd0, valid_out}, 32'd0);
    chk("pc_out", pc_out, 32'd0);
    rst = 1'b1; mif.mem_ack = 1'b1; mif.mem_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("valid_late_ack", {31'd0, valid_out}, 32'd0);
    chk("stall_late_ack", {31'd0, stall_out}, 32'd0);
    chk("mem_err", {31'd0, mem_err}, 32'd0);
    mif.mem_ack = 1'b0;
    err_model = 1'b0;
    v = '{1'b0, 32'h48, 32'h6, 32'h0, 32'h13, 22'h0, 0, 32'h0, 0, 32'h0, 1'b0};
    run_instr(model(v, err_model));

    for (int i = 0; i < 160; i++) begin
      $sformat(cur_tag, "rand%0d", i);
      if (i % 10 == 0) do_reset();
      tmp = $urandom();
      if ($urandom_range(0, 9) != 0) tmp[1:0] = 2'b00;
      v.rst_before = 1'b0;
      v.pc   = $urandom();
      v.alu  = tmp;
      v.op2  = $urandom();
      v.inst = $urandom();
      v.ctrl = 22'($urandom());
      kind = $urandom_range(0, 3);
      v.ctrl[0] = (kind == 1) || (kind == 3);
      v.ctrl[1] = (kind == 2) || (kind == 3);
      r = $urandom_range(0, 19);
      v.ack_at = (r < 2) ? 0 : (r < 4) ? TO + 1 : $urandom_range(1, TO);
      v.rdata = $urandom();
      v = model(v, err_model);
      err_model = v.exp_err;
      run_instr(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT, default 15, meaning: number of WAIT cycles without mem_ack before forced completion (legal range 1..255).
REQ-002 Parameter IDX_LD, default 0, meaning: control_in bit index of isLd.
REQ-003 Parameter IDX_ST, default 1, meaning: control_in bit index of isSt.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 valid_in  input  1  execute stage presents an instruction.
REQ-007 pc_in, aluResult_in, op2_in, inst_in  input  32 each  execute-stage results; op2_in is store data.
REQ-008 control_in  input  22  decoded control word.
REQ-009 stall_out  output  1  upstream must hold inputs and valid_in while high.
REQ-010 mem_req, mem_we  output  1 each  data-memory request and write enable.
REQ-011 mem_addr, mem_wdata  output  32 each  memory address (aluResult) and store data.
REQ-012 mem_rdata  input  32  load data, sampled only when mem_ack=1.
REQ-013 mem_ack  input  1  memory completion, single-cycle pulse.
REQ-014 valid_out  output  1  one-cycle pulse: pc_out, ldResult, aluResult_out, inst_out, control_out valid for the writeback stage.
REQ-015 pc_out, ldResult, aluResult_out, inst_out  output  32 each; control_out  output  22.
REQ-016 mem_err  output  1  sticky error flag (timeout or misaligned access).

Function
REQ-017 FSM states IDLE and WAIT; stall_out = (state == WAIT).
REQ-018 IDLE, valid_in=1, neither isLd nor isSt: next edge loads output registers, ldResult=0, and pulses valid_out=1 (latency 1).
REQ-019 IDLE, valid_in=1, isLd or isSt, aligned address (aluResult_in[1:0]=0): next edge captures all inputs into hold registers, clears the timeout counter, and enters WAIT with valid_out=0.
REQ-020 Misaligned load/store in IDLE: no memory request; completes as in REQ-018 with ldResult=0, and mem_err is set.
REQ-021 WAIT: mem_req=1, mem_we=held isSt, mem_addr=held aluResult, mem_wdata=held op2; all are stable until exit.
REQ-022 WAIT and mem_ack=1: next edge loads outputs from the hold registers, sets ldResult=mem_rdata for a load or 0 for a store, pulses valid_out, and returns to IDLE.
REQ-023 WAIT without ack: the 8-bit counter increments each cycle; at count == TIMEOUT-1 with no ack, completion proceeds as REQ-022 with ldResult=0 and mem_err set.
REQ-024 If mem_ack and timeout occur in the same cycle, ack wins, and mem_err is not set by that event.
REQ-025 mem_ack in IDLE is ignored.
REQ-026 valid_in while in WAIT is ignored; upstream holds it, and it is accepted on the first IDLE cycle.
REQ-027 Both isLd and isSt set: treated as a load.
REQ-028 mem_req, mem_we, mem_addr, and mem_wdata are 0 in IDLE.

Reset
REQ-029 rst=0 at an edge: state=IDLE, counter=0, hold registers=0, mem_err=0, valid_out=0, and all data outputs=0.
REQ-030 Reset during WAIT abandons the access: mem_req drops the cycle after the reset edge, and no valid_out is produced for the aborted instruction.
REQ-031 mem_err is cleared only by reset.

Structure
REQ-032 A shared package holds the 22-bit control-word type, the isLd/isSt/isCall bit-index constants (0, 1, 4), and the FSM state enum.
REQ-033 The timeout counter is a sub-module ma_timeout_ctr with inputs clr and en and output expired.

Verification
REQ-034 ALU op: pc_in=0x10, aluResult_in=0x5, control_in=0 -> one edge later, valid_out=1, aluResult_out=0x5, ldResult=0, and stall_out never rises.
REQ-035 Load: aluResult_in=0x100, isLd; mem_ack after 3 WAIT cycles with mem_rdata=0xA -> mem_req=1 for exactly 3 cycles, then valid_out with ldResult=0xA.
REQ-036 Store: aluResult_in=0x200, op2_in=0xDEADBEEF, isSt -> mem_we=1, mem_wdata=0xDEADBEEF; after ack, valid_out=1 and ldResult=0.
REQ-037 Timeout: load with no ack, TIMEOUT=15 -> valid_out after 15 WAIT cycles with ldResult=0, and mem_err=1 stays set.
REQ-038 Misaligned: isLd, aluResult_in=0x102 -> mem_req stays 0, valid_out on the next edge, and mem_err=1.
REQ-039 Reset mid-WAIT: rst=0 on the 2nd WAIT cycle -> state returns to IDLE, mem_req=0, and no valid_out; a following ALU op completes normally.
